// File: rtl/tri_input_queue.sv
// Elastic triangle queue ahead of rast: buffers up to DEPTH triangles and
// retires the head only on cycles where rast is not halting.
module tri_input_queue #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int DEPTH  = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R9S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]          color_R9U,
  input  logic                                          validTri_R9H,
  output logic                                          ready_R9H,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S,
  output logic        [COLORS-1:0][SIGFIG-1:0]          color_R10U,
  output logic                                          validTri_R10H,
  input  logic                                          halt_RnnnnL,
  input  logic                                          flush_RnnnnH,
  output logic [$clog2(DEPTH+1)-1:0]                    count_RnnnnU,
  output logic [31:0]                                   tri_cnt_RnnnnU,
  output logic [31:0]                                   stall_cnt_RnnnnU
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_mem   [DEPTH];
  logic        [COLORS-1:0][SIGFIG-1:0]          color_mem [DEPTH];

  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // No pass-through when full: ready depends only on occupancy and reset.
  assign ready_R9H     = rst && (count != CW'(DEPTH));
  assign validTri_R10H = (count != '0);
  assign push          = validTri_R9H && ready_R9H && !flush_RnnnnH;
  assign pop           = validTri_R10H && halt_RnnnnL && !flush_RnnnnH;

  assign tri_R10S      = validTri_R10H ? tri_mem[rptr]   : '0;
  assign color_R10U    = validTri_R10H ? color_mem[rptr] : '0;
  assign count_RnnnnU  = count;

  always_ff @(posedge clk) begin
    if (push) begin
      tri_mem[wptr]   <= tri_R9S;
      color_mem[wptr] <= color_R9U;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush_RnnnnH) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Stats survive flush; stalls are counted on flush cycles too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tri_cnt_RnnnnU   <= '0;
      stall_cnt_RnnnnU <= '0;
    end else begin
      if (pop) tri_cnt_RnnnnU <= tri_cnt_RnnnnU + 32'd1;
      if (validTri_R10H && !halt_RnnnnL) stall_cnt_RnnnnU <= stall_cnt_RnnnnU + 32'd1;
    end
  end

endmodule

// File: tb/tb_tri_input_queue.sv
// Scoreboard bench for tri_input_queue: a queue model tracks accepted ids
// and checks head data, occupancy, handshake and stats every cycle.
module tb_tri_input_queue;
  localparam int SIGFIG = 24;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH+1);

  typedef logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0]                 col_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  tri_t          tri_R9S = '0;
  col_t          color_R9U = '0;
  logic          validTri_R9H = 1'b0;
  logic          ready_R9H;
  tri_t          tri_R10S;
  col_t          color_R10U;
  logic          validTri_R10H;
  logic          halt_RnnnnL = 1'b0;
  logic          flush_RnnnnH = 1'b0;
  logic [CW-1:0] count_RnnnnU;
  logic [31:0]   tri_cnt_RnnnnU;
  logic [31:0]   stall_cnt_RnnnnU;

  tri_input_queue #(
    .SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS), .DEPTH(DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R9S          (tri_R9S),
    .color_R9U        (color_R9U),
    .validTri_R9H     (validTri_R9H),
    .ready_R9H        (ready_R9H),
    .tri_R10S         (tri_R10S),
    .color_R10U       (color_R10U),
    .validTri_R10H    (validTri_R10H),
    .halt_RnnnnL      (halt_RnnnnL),
    .flush_RnnnnH     (flush_RnnnnH),
    .count_RnnnnU     (count_RnnnnU),
    .tri_cnt_RnnnnU   (tri_cnt_RnnnnU),
    .stall_cnt_RnnnnU (stall_cnt_RnnnnU)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          sb[$];
  logic [31:0] exp_tri = '0;
  logic [31:0] exp_stall = '0;
  int          next_id = 1;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic tri_t make_tri(input int id);
    tri_t t;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        t[v][a] = 24'(id) + 24'(v*AXIS + a) * 24'h1000;
    return t;
  endfunction

  function automatic col_t make_col(input int id);
    col_t c;
    for (int k = 0; k < COLORS; k++)
      c[k] = 24'(id) ^ (24'(k+1) << 20);
    return c;
  endfunction

  // Checks state left by the previous edge, then applies the ops the next edge will perform.
  always @(negedge clk) begin
    bit full;
    if (!rst) begin
      sb.delete();
      exp_tri   = '0;
      exp_stall = '0;
    end
    check_val("count",     count_RnnnnU, sb.size());
    check_val("ready",     ready_R9H, rst && (sb.size() != DEPTH));
    check_val("valid",     validTri_R10H, sb.size() != 0);
    check_val("tri_cnt",   tri_cnt_RnnnnU, exp_tri);
    check_val("stall_cnt", stall_cnt_RnnnnU, exp_stall);
    if (sb.size() == 0) begin
      check_val("empty_tri", tri_R10S, '0);
      check_val("empty_col", color_R10U, '0);
    end else begin
      check_val("head_tri", tri_R10S, make_tri(sb[0]));
      check_val("head_col", color_R10U, make_col(sb[0]));
    end
    if (rst) begin
      full = (sb.size() == DEPTH);
      if (sb.size() != 0 && !halt_RnnnnL) exp_stall = exp_stall + 32'd1;
      if (flush_RnnnnH) begin
        sb.delete();
      end else begin
        if (sb.size() != 0 && halt_RnnnnL) begin
          void'(sb.pop_front());
          exp_tri = exp_tri + 32'd1;
        end
        if (validTri_R9H && !full) sb.push_back(next_id);
      end
    end
  end

  task automatic drive(input bit v, input bit h, input bit f);
    bit acc;
    validTri_R9H = v;
    halt_RnnnnL  = h;
    flush_RnnnnH = f;
    tri_R9S      = make_tri(next_id);
    color_R9U    = make_col(next_id);
    acc = v && ready_R9H && !f;
    @(posedge clk);
    #1;
    if (acc) next_id++;
  endtask

  initial begin
    // Reset held with a push pending
    @(posedge clk); #1;
    repeat (3) drive(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_val("ready_after_rst", ready_R9H, 1'b1);

    // Fill while rast halts, then drain; id 5 goes in once a slot opens
    repeat (8) drive(1'b1, 1'b0, 1'b0);
    check_val("fill_count", count_RnnnnU, 4);
    check_val("fill_ready", ready_R9H, 1'b0);
    check_val("fill_next",  next_id, 5);
    repeat (10) drive(next_id <= 5, 1'b1, 1'b0);
    check_val("drain_tri_cnt", tri_cnt_RnnnnU, 5);
    check_val("drain_valid",   validTri_R10H, 1'b0);

    // Streaming, one triangle per cycle
    repeat (20) drive(1'b1, 1'b1, 1'b0);
    repeat (2)  drive(1'b0, 1'b1, 1'b0);
    check_val("stream_tri_cnt", tri_cnt_RnnnnU, 25);

    // Full with simultaneous pop: push refused, then accepted
    repeat (4) drive(1'b1, 1'b0, 1'b0);
    check_val("full_count", count_RnnnnU, 4);
    drive(1'b1, 1'b1, 1'b0);
    check_val("full_pop_count", count_RnnnnU, 3);
    drive(1'b1, 1'b0, 1'b0);
    check_val("refill_count", count_RnnnnU, 4);
    drive(1'b0, 1'b1, 1'b0);
    check_val("pre_flush_count", count_RnnnnU, 3);

    // Flush with push and pop requested in the same cycle
    drive(1'b1, 1'b1, 1'b1);
    check_val("flush_count",   count_RnnnnU, 0);
    check_val("flush_valid",   validTri_R10H, 1'b0);
    check_val("flush_tri_cnt", tri_cnt_RnnnnU, 27);
    drive(1'b1, 1'b0, 1'b0);
    check_val("post_flush_head", tri_R10S[0][0], 24'(next_id - 1));
    drive(1'b0, 1'b1, 1'b0);
    check_val("post_flush_tri_cnt", tri_cnt_RnnnnU, 28);

    // Asynchronous reset between edges
    repeat (2) drive(1'b1, 1'b0, 1'b0);
    check_val("pre_rst_count", count_RnnnnU, 2);
    #2;
    rst = 1'b0;
    #1;
    check_val("arst_valid",     validTri_R10H, 1'b0);
    check_val("arst_ready",     ready_R9H, 1'b0);
    check_val("arst_count",     count_RnnnnU, 0);
    check_val("arst_tri",       tri_R10S, '0);
    check_val("arst_col",       color_R10U, '0);
    check_val("arst_tri_cnt",   tri_cnt_RnnnnU, 0);
    check_val("arst_stall_cnt", stall_cnt_RnnnnU, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
